// File: rtl/imem_fetch_port.sv
// Instruction memory fetch port.
// Accepts byte-addressed fetch requests and reads the word one cycle later.
// Up to two responses are held in an in-order buffer, and the request side
// is throttled so that buffer can never overflow.
// A separate program-load write port fills the memory. Faulted fetches
// return NOP_WORD together with a fault code.
module imem_fetch_port #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(32'h00000013)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_req_valid,
    output logic                       out_req_ready,
    input  logic [ADDR_WIDTH-1:0]      in_address,
    output logic                       out_resp_valid,
    input  logic                       in_resp_ready,
    output logic [DATA_WIDTH-1:0]      out_instruction,
    output logic [1:0]                 out_fault,
    input  logic                       in_flush,
    input  logic                       in_load_en,
    input  logic [$clog2(DEPTH)-1:0]   in_load_index,
    input  logic [DATA_WIDTH-1:0]      in_load_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(DATA_WIDTH / 8);

    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;

    // Program storage; deliberately has no reset so contents survive reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read stage: the word read at the accept edge, waiting to enter the buffer.
    logic                  stg_vld_q;
    logic [DATA_WIDTH-1:0] stg_data_q;
    logic [1:0]            stg_fault_q;

    // Two-entry response buffer; entry 0 is always the head.
    logic [1:0]            buf_cnt_q,   buf_cnt_d;
    logic [DATA_WIDTH-1:0] buf_data_q  [2];
    logic [DATA_WIDTH-1:0] buf_data_d  [2];
    logic [1:0]            buf_fault_q [2];
    logic [1:0]            buf_fault_d [2];

    logic                  consume;
    logic                  accept;
    logic [2:0]            occupancy;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic [1:0]            req_fault;
    logic                  load_in_range;

    // Handshake decisions and request address decode.
    always_comb begin
        consume       = (buf_cnt_q != 2'd0) && in_resp_ready;
        // Slots committed after this edge: buffered + in flight - leaving now.
        occupancy     = 3'(buf_cnt_q) + 3'(stg_vld_q) - 3'(consume);
        out_req_ready = !reset && !in_flush && (occupancy < 3'd2);
        accept        = in_req_valid && out_req_ready;

        word_idx      = in_address >> OFF_W;
        misaligned    = |in_address[OFF_W-1:0];
        out_of_range  = !misaligned && (word_idx >= ADDR_WIDTH'(DEPTH));
        if (misaligned) begin
            req_fault = FAULT_ALIGN;
        end else if (out_of_range) begin
            req_fault = FAULT_RANGE;
        end else begin
            req_fault = FAULT_OK;
        end

        load_in_range = 32'(in_load_index) < DEPTH;
    end

    // Program-load writes; reset blocks writes but never clears the array.
    always_ff @(posedge clk) begin
        if (!reset && in_load_en && load_in_range) begin
            mem[in_load_index] <= in_load_data;
        end
    end

    // Read stage. Reading in the same edge as a load returns pre-write data.
    always_ff @(posedge clk) begin
        if (reset || in_flush) begin
            stg_vld_q   <= 1'b0;
            stg_data_q  <= '0;
            stg_fault_q <= FAULT_OK;
        end else begin
            stg_vld_q <= accept;
            if (accept) begin
                stg_data_q  <= (req_fault != FAULT_OK) ? NOP_WORD : mem[word_idx[IDX_W-1:0]];
                stg_fault_q <= req_fault;
            end
        end
    end

    // Buffer next state: pop the head on consume, then append the read stage.
    always_comb begin
        buf_cnt_d      = buf_cnt_q;
        buf_data_d[0]  = buf_data_q[0];
        buf_data_d[1]  = buf_data_q[1];
        buf_fault_d[0] = buf_fault_q[0];
        buf_fault_d[1] = buf_fault_q[1];
        if (consume) begin
            buf_data_d[0]  = buf_data_q[1];
            buf_fault_d[0] = buf_fault_q[1];
            buf_cnt_d      = buf_cnt_q - 2'd1;
        end
        if (stg_vld_q) begin
            buf_data_d[buf_cnt_d[0]]  = stg_data_q;
            buf_fault_d[buf_cnt_d[0]] = stg_fault_q;
            buf_cnt_d                 = buf_cnt_d + 2'd1;
        end
    end

    // Buffer registers; reset and flush drop everything outstanding.
    always_ff @(posedge clk) begin
        if (reset || in_flush) begin
            buf_cnt_q      <= 2'd0;
            buf_data_q[0]  <= '0;
            buf_data_q[1]  <= '0;
            buf_fault_q[0] <= FAULT_OK;
            buf_fault_q[1] <= FAULT_OK;
        end else begin
            buf_cnt_q      <= buf_cnt_d;
            buf_data_q[0]  <= buf_data_d[0];
            buf_data_q[1]  <= buf_data_d[1];
            buf_fault_q[0] <= buf_fault_d[0];
            buf_fault_q[1] <= buf_fault_d[1];
        end
    end

    assign out_resp_valid  = (buf_cnt_q != 2'd0);
    assign out_instruction = buf_data_q[0];
    assign out_fault       = buf_fault_q[0];

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed testbench for imem_fetch_port with hand-computed expectations.
module tb_imem_fetch_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_req_valid;
    logic        out_req_ready;
    logic [31:0] in_address;
    logic        out_resp_valid;
    logic        in_resp_ready;
    logic [31:0] out_instruction;
    logic [1:0]  out_fault;
    logic        in_flush;
    logic        in_load_en;
    logic [7:0]  in_load_index;
    logic [31:0] in_load_data;

    int checks = 0;
    int errors = 0;

    imem_fetch_port #(
        .DATA_WIDTH (32),
        .DEPTH      (256),
        .ADDR_WIDTH (32),
        .NOP_WORD   (32'h00000013)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_req_valid    (in_req_valid),
        .out_req_ready   (out_req_ready),
        .in_address      (in_address),
        .out_resp_valid  (out_resp_valid),
        .in_resp_ready   (in_resp_ready),
        .out_instruction (out_instruction),
        .out_fault       (out_fault),
        .in_flush        (in_flush),
        .in_load_en      (in_load_en),
        .in_load_index   (in_load_index),
        .in_load_data    (in_load_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One isolated fetch with in_resp_ready high: response appears one edge
    // after the accept edge and is consumed on the following edge.
    task automatic fetch_one(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_instr, input logic [1:0] exp_fault);
        in_resp_ready = 1'b1;
        in_req_valid  = 1'b1;
        in_address    = addr;
        #1;
        check({tag, "_ready"}, out_req_ready, 1'b1);
        cycle();
        in_req_valid = 1'b0;
        check({tag, "_lat_valid"}, out_resp_valid, 1'b0);
        cycle();
        check({tag, "_valid"}, out_resp_valid, 1'b1);
        check({tag, "_instr"}, out_instruction, exp_instr);
        check({tag, "_fault"}, out_fault, exp_fault);
        cycle();
        check({tag, "_drain"}, out_resp_valid, 1'b0);
    endtask

    logic [31:0] bp_addr [4];
    logic        bp_ready_exp [4];
    int          acc;

    initial begin
        reset         = 1'b1;
        in_req_valid  = 1'b0;
        in_address    = '0;
        in_resp_ready = 1'b0;
        in_flush      = 1'b0;
        in_load_en    = 1'b0;
        in_load_index = '0;
        in_load_data  = '0;

        // Reset state
        cycle();
        cycle();
        check("rst_valid", out_resp_valid, 1'b0);
        check("rst_fault", out_fault, 2'b00);
        check("rst_instr", out_instruction, 32'h0);
        in_req_valid = 1'b1;
        #1;
        check("rst_ready", out_req_ready, 1'b0);
        in_req_valid = 1'b0;

        reset = 1'b0;
        #1;
        check("post_rst_ready", out_req_ready, 1'b1);

        // Program load: words 0..3 = A0..A3, word 5 = 0x55
        for (int i = 0; i < 4; i++) begin
            in_load_en    = 1'b1;
            in_load_index = 8'(i);
            in_load_data  = 32'hA0 + 32'(i);
            cycle();
        end
        in_load_index = 8'd5;
        in_load_data  = 32'h55;
        cycle();
        in_load_en = 1'b0;

        // Back-to-back fetches at full throughput
        in_resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_req_valid = (i < 4);
            in_address   = 32'(i * 4);
            #1;
            if (i < 4) check($sformatf("b2b_ready%0d", i), out_req_ready, 1'b1);
            cycle();
            if (i == 0 || i == 5) begin
                check($sformatf("b2b_valid%0d", i), out_resp_valid, 1'b0);
            end else begin
                check($sformatf("b2b_valid%0d", i), out_resp_valid, 1'b1);
                check($sformatf("b2b_instr%0d", i), out_instruction, 32'hA0 + 32'(i - 1));
                check($sformatf("b2b_fault%0d", i), out_fault, 2'b00);
            end
        end
        in_req_valid = 1'b0;

        // Fault cases
        fetch_one("misal2",  32'h2,   32'h13, 2'b01);
        fetch_one("range400", 32'h400, 32'h13, 2'b10);
        fetch_one("misal401", 32'h401, 32'h13, 2'b01);
        fetch_one("last_ok", 32'h4,   32'hA1, 2'b00);

        // Backpressure: 4 attempts with the consumer stalled
        bp_addr[0] = 32'h8;  bp_addr[1] = 32'hC; bp_addr[2] = 32'h0; bp_addr[3] = 32'h4;
        bp_ready_exp[0] = 1'b1; bp_ready_exp[1] = 1'b1;
        bp_ready_exp[2] = 1'b0; bp_ready_exp[3] = 1'b0;
        in_resp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            in_req_valid = 1'b1;
            in_address   = bp_addr[acc];
            #1;
            check($sformatf("bp_ready%0d", i), out_req_ready, bp_ready_exp[i]);
            if (out_req_ready) acc++;
            cycle();
        end
        check("bp_accepted", 32'(acc), 32'd2);
        check("bp_full_ready", out_req_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("bp_hold_valid%0d", i), out_resp_valid, 1'b1);
            check($sformatf("bp_hold_instr%0d", i), out_instruction, 32'hA2);
            check($sformatf("bp_hold_fault%0d", i), out_fault, 2'b00);
            cycle();
        end
        in_req_valid  = 1'b0;
        in_resp_ready = 1'b1;
        #1;
        check("bp_release_ready", out_req_ready, 1'b1);
        cycle();
        check("bp_second_valid", out_resp_valid, 1'b1);
        check("bp_second_instr", out_instruction, 32'hA3);
        cycle();
        check("bp_empty", out_resp_valid, 1'b0);

        // Flush with two buffered responses
        in_resp_ready = 1'b0;
        in_req_valid  = 1'b1;
        in_address    = 32'h0;
        cycle();
        in_address    = 32'h4;
        cycle();
        in_req_valid  = 1'b0;
        cycle();
        check("fl_pre_valid", out_resp_valid, 1'b1);
        in_flush     = 1'b1;
        in_req_valid = 1'b1;
        in_address   = 32'h8;
        #1;
        check("fl_ready", out_req_ready, 1'b0);
        cycle();
        in_flush     = 1'b0;
        in_req_valid = 1'b0;
        check("fl_valid", out_resp_valid, 1'b0);
        cycle();
        check("fl_no_stale", out_resp_valid, 1'b0);
        fetch_one("fl_next", 32'hC, 32'hA3, 2'b00);

        // Load and fetch of the same word on one edge
        in_resp_ready = 1'b1;
        in_load_en    = 1'b1;
        in_load_index = 8'd5;
        in_load_data  = 32'hBEEF;
        in_req_valid  = 1'b1;
        in_address    = 32'd20;
        cycle();
        in_load_en   = 1'b0;
        in_req_valid = 1'b0;
        cycle();
        check("raw_valid", out_resp_valid, 1'b1);
        check("raw_old", out_instruction, 32'h55);
        cycle();
        fetch_one("raw_new", 32'd20, 32'hBEEF, 2'b00);

        // Reset mid-operation: one buffered, one in flight; load blocked
        in_resp_ready = 1'b0;
        in_req_valid  = 1'b1;
        in_address    = 32'h0;
        cycle();
        in_address    = 32'h4;
        cycle();
        in_req_valid  = 1'b0;
        reset         = 1'b1;
        in_load_en    = 1'b1;
        in_load_index = 8'd1;
        in_load_data  = 32'hDEAD;
        #1;
        check("mrst_ready_comb", out_req_ready, 1'b0);
        cycle();
        in_load_en = 1'b0;
        check("mrst_valid", out_resp_valid, 1'b0);
        check("mrst_instr", out_instruction, 32'h0);
        check("mrst_fault", out_fault, 2'b00);
        check("mrst_ready", out_req_ready, 1'b0);
        cycle();
        reset         = 1'b0;
        in_resp_ready = 1'b1;
        cycle();
        check("mrst_no_stale", out_resp_valid, 1'b0);
        fetch_one("mrst_mem1", 32'h4,  32'hA1,   2'b00);
        fetch_one("mrst_mem5", 32'd20, 32'hBEEF, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
